// File: rtl/data_memory_pkg.sv
// Shared types and defaults for the CPU data RAM and its clear sweeper.
package data_memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_DEPTH  = 4096;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_memory_clear_sweeper.sv
// Zeroing sweep controller: walks every word once after reset or clear,
// one word per cycle, then reports done until the next clear.
module clear_sweeper
  import data_memory_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr,
  output logic [CW-1:0] sweep_addr,
  output logic          sweep_we,
  output logic          sweep_done
);

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (clr) begin
      state_n = ST_CLEAR;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        ST_IDLE: ;
        default: ;
      endcase
    end
  end

  // While clr is held word 0 is rewritten every cycle; res blocks any write.
  assign sweep_addr = clr ? '0 : cnt;
  assign sweep_we   = ~res & (clr | (state == ST_CLEAR));
  assign sweep_done = (state == ST_IDLE);

endmodule

// File: rtl/data_memory.sv
// CPU data RAM: combinational loads, clocked stores, hardware zeroing sweep
// after reset/clear, and a sticky fault flag for rejected accesses.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              res,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              sel,
  input  logic              ld,
  input  logic              clr,
  output logic              ready,
  output logic              err
);

  localparam int unsigned     CW    = cnt_width(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CW-1:0] sweep_addr;
  logic          sweep_we;
  logic          sweep_done;
  logic          in_range;
  logic [CW-1:0] idx;
  logic          cpu_we;

  clear_sweeper #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_sweeper (
    .clk        (clk),
    .res        (res),
    .clr        (clr),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we),
    .sweep_done (sweep_done)
  );

  assign in_range = {1'b0, addr} < LIMIT;
  assign idx      = CW'(addr);
  assign cpu_we   = sel & ~ld & sweep_done & in_range & ~clr;
  assign rdata    = (sel & ld & sweep_done & in_range) ? mem[idx] : '0;
  assign ready    = sweep_done;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (cpu_we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (sel & ~(sweep_done & in_range)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: a full-depth instance and a DEPTH=3000 instance,
// each compared every cycle against a word-array reference model.
module tb_data_memory;

  localparam int D0 = 4096;
  localparam int D1 = 3000;

  logic        clk;
  logic        res;
  logic [1:0]  sel, ld, clr;
  logic [11:0] addr  [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic [1:0]  ready, err;

  int n_checks, n_fail;

  data_memory #(.ADDR_W(12), .DATA_W(16), .DEPTH(D0)) dut (
    .clk(clk), .res(res), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
    .sel(sel[0]), .ld(ld[0]), .clr(clr[0]), .ready(ready[0]), .err(err[0])
  );

  data_memory #(.ADDR_W(12), .DATA_W(16), .DEPTH(D1)) dut_s (
    .clk(clk), .res(res), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
    .sel(sel[1]), .ld(ld[1]), .clr(clr[1]), .ready(ready[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycles of sweep still owed, sticky fault, word contents.
  int          m_rem   [2];
  bit          m_err   [2];
  int          m_depth [2];
  logic [15:0] m_mem   [2][4096];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void m_sweep_start(input int m);
    m_rem[m] = m_depth[m];
    m_err[m] = 1'b0;
    for (int i = 0; i < 4096; i++) m_mem[m][i] = 16'h0000;
  endfunction

  function automatic logic [15:0] m_rdata(input int m);
    if (m_rem[m] == 0 && sel[m] && ld[m] && addr[m] < m_depth[m]) return m_mem[m][addr[m]];
    return 16'h0000;
  endfunction

  function automatic void m_edge(input int m);
    if (res || clr[m]) begin
      m_sweep_start(m);
    end else if (m_rem[m] > 0) begin
      m_rem[m]--;
      if (sel[m]) m_err[m] = 1'b1;
    end else if (sel[m]) begin
      if (addr[m] >= m_depth[m]) m_err[m] = 1'b1;
      else if (!ld[m]) m_mem[m][addr[m]] = wdata[m];
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("ready%0d", m), ready[m], (m_rem[m] == 0));
      check($sformatf("err%0d", m), err[m], m_err[m]);
      check($sformatf("rdata%0d", m), rdata[m], m_rdata(m));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) m_edge(m);
    #1;
  endtask

  task automatic set_idle(input int m);
    sel[m] = 1'b0; ld[m] = 1'b0; clr[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
  endtask

  task automatic access(input int m, input logic l, input logic [11:0] a, input logic [15:0] d);
    sel[m] = 1'b1; ld[m] = l; addr[m] = a; wdata[m] = d; clr[m] = 1'b0;
  endtask

  task automatic wait_ready(input int m, input int exp, input string name);
    int n = 0;
    while (!ready[m] && n < 6000) begin
      cycle();
      n++;
    end
    check(name, n, exp);
  endtask

  typedef struct {
    logic        sel;
    logic        ld;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [11:0] samp [3];
    int n_clr;
    n_checks = 0;
    n_fail   = 0;
    m_depth[0] = D0;
    m_depth[1] = D1;
    res = 1'b1;
    set_idle(0);
    set_idle(1);
    m_sweep_start(0);
    m_sweep_start(1);

    // Reset release and full sweep
    repeat (3) cycle();
    check("reset_ready", ready[0], 1'b0);
    check("reset_err", err[0], 1'b0);
    res = 1'b0;
    wait_ready(0, 4096, "ready_after_reset");
    check("small_ready_after_reset", ready[1], 1'b1);
    samp[0] = 12'd0; samp[1] = 12'd1234; samp[2] = 12'd4095;
    for (int i = 0; i < 3; i++) begin
      access(0, 1'b1, samp[i], 16'h0);
      #1 check("swept_read", rdata[0], 16'h0000);
      cycle();
    end

    // Store/load table
    tbl[0] = '{1'b1, 1'b0, 12'h005, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 12'hFFF, 16'h1234, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 12'h005, 16'h0000, 16'hBEEF};
    tbl[3] = '{1'b1, 1'b1, 12'hFFF, 16'h0000, 16'h1234};
    tbl[4] = '{1'b0, 1'b1, 12'h005, 16'h0000, 16'h0000};
    tbl[5] = '{1'b1, 1'b1, 12'h006, 16'h0000, 16'h0000};
    tbl[6] = '{1'b1, 1'b0, 12'h006, 16'h0001, 16'h0000};
    tbl[7] = '{1'b1, 1'b1, 12'h006, 16'h0000, 16'h0001};
    tbl[8] = '{1'b1, 1'b0, 12'h005, 16'h7777, 16'h0000};
    tbl[9] = '{1'b1, 1'b1, 12'h005, 16'h0000, 16'h7777};
    for (int i = 0; i < 10; i++) begin
      sel[0] = tbl[i].sel; ld[0] = tbl[i].ld; addr[0] = tbl[i].addr; wdata[0] = tbl[i].wdata;
      #1;
      check($sformatf("tbl%0d_rdata", i), rdata[0], tbl[i].exp_rdata);
      check($sformatf("tbl%0d_err", i), err[0], 1'b0);
      cycle();
    end

    // Clear held for three cycles
    set_idle(0);
    clr[0] = 1'b1;
    repeat (3) cycle();
    check("clr_ready", ready[0], 1'b0);
    check("clr_err", err[0], 1'b0);
    clr[0] = 1'b0;
    wait_ready(0, 4096, "ready_after_clr");
    access(0, 1'b1, 12'h005, 16'h0);
    #1 check("cleared_read", rdata[0], 16'h0000);
    cycle();

    // Store while the sweep is running
    set_idle(0);
    clr[0] = 1'b1;
    cycle();
    access(0, 1'b0, 12'd7, 16'hAAAA);
    #1 check("sweep_store_rdata", rdata[0], 16'h0000);
    cycle();
    check("sweep_access_err", err[0], 1'b1);
    set_idle(0);
    wait_ready(0, 4095, "ready_after_sweep_access");
    access(0, 1'b1, 12'd7, 16'h0);
    #1 check("dropped_write_read", rdata[0], 16'h0000);
    check("err_sticky", err[0], 1'b1);
    cycle();
    set_idle(0);
    clr[0] = 1'b1;
    cycle();
    clr[0] = 1'b0;
    check("err_cleared_by_clr", err[0], 1'b0);
    wait_ready(0, 4096, "ready_after_err_clr");

    // Out-of-range on the DEPTH=3000 instance
    access(1, 1'b0, 12'd3000, 16'h5555);
    #1 check("oor_store_rdata", rdata[1], 16'h0000);
    cycle();
    check("oor_err", err[1], 1'b1);
    access(1, 1'b1, 12'd3000, 16'h0);
    #1 check("oor_read", rdata[1], 16'h0000);
    cycle();
    access(1, 1'b0, 12'd2999, 16'h0ABC);
    cycle();
    access(1, 1'b1, 12'd2999, 16'h0);
    #1 check("last_word_read", rdata[1], 16'h0ABC);
    cycle();
    set_idle(1);

    // Randomised traffic against the model
    n_clr = 0;
    for (int it = 0; it < 1500; it++) begin
      for (int m = 0; m < 2; m++) begin
        sel[m] = ($urandom_range(0, 3) != 0);
        ld[m]  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       addr[m] = 12'($urandom_range(0, 15));
          1:       addr[m] = 12'($urandom_range(2990, 3010));
          2:       addr[m] = 12'($urandom_range(4088, 4095));
          default: addr[m] = 12'($urandom_range(0, 4095));
        endcase
        wdata[m] = 16'($urandom);
        clr[m]   = 1'b0;
        if (n_clr < 2 && $urandom_range(0, 499) == 0) begin
          clr[m] = 1'b1;
          n_clr++;
        end
      end
      cycle();
    end
    set_idle(0);
    set_idle(1);
    for (int n = 0; n < 5000 && ready != 2'b11; n++) cycle();
    check("settle_ready", ready, 2'b11);

    // Asynchronous reset 100 words into a sweep
    clr[0] = 1'b1;
    cycle();
    access(0, 1'b1, 12'd0, 16'h0);
    cycle();
    set_idle(0);
    repeat (99) cycle();
    check("err_before_reset", err[0], 1'b1);
    #2;
    res = 1'b1;
    m_sweep_start(0);
    m_sweep_start(1);
    #1;
    check("async_ready_low", ready[0], 1'b0);
    check("async_err_drop", err[0], 1'b0);
    check("async_ready_drop", ready[1], 1'b0);
    repeat (2) cycle();
    res = 1'b0;
    wait_ready(0, 4096, "ready_after_async_reset");
    check("small_ready_after_async", ready[1], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
